// File: rtl/hsv_core_issue_regfile_ctrl.sv
// Issue-stage register file controller: 3-state operand read FSM with write bypass and a
// two-requester round-robin writeback arbiter driving a single regfile write port.
module hsv_core_issue_regfile_ctrl #(
   parameter int unsigned NUM_REGS = 32
) (
   input  logic                        clk_core,
   input  logic                        rst,
   input  logic                        rd_req_valid,
   output logic                        rd_req_ready,
   input  logic [$clog2(NUM_REGS)-1:0] rd_rs1_addr,
   input  logic [$clog2(NUM_REGS)-1:0] rd_rs2_addr,
   output logic                        rd_rsp_valid,
   input  logic                        rd_rsp_ready,
   output logic [31:0]                 rd_rs1_data,
   output logic [31:0]                 rd_rs2_data,
   output logic [$clog2(NUM_REGS)-1:0] rf_rs1_addr,
   output logic [$clog2(NUM_REGS)-1:0] rf_rs2_addr,
   input  logic [31:0]                 rf_rs1_data,
   input  logic [31:0]                 rf_rs2_data,
   output logic                        rf_wr_en,
   output logic [$clog2(NUM_REGS)-1:0] rf_wr_addr,
   output logic [31:0]                 rf_wr_data,
   input  logic                        wb_a_valid,
   output logic                        wb_a_ready,
   input  logic [$clog2(NUM_REGS)-1:0] wb_a_addr,
   input  logic [31:0]                 wb_a_data,
   input  logic                        wb_b_valid,
   output logic                        wb_b_ready,
   input  logic [$clog2(NUM_REGS)-1:0] wb_b_addr,
   input  logic [31:0]                 wb_b_data
);

   localparam int unsigned AddrW = $clog2(NUM_REGS);

   typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

   state_e            r_state, w_state_nxt;
   logic [AddrW-1:0]  r_rs1_addr, r_rs2_addr;
   logic [31:0]       r_rs1_data, r_rs2_data;
   logic              r_byp1_vld, r_byp2_vld;
   logic [31:0]       r_byp1_data, r_byp2_data;
   logic              r_last_b;
   logic              w_grant_a, w_grant_b;

   // Ties go to whichever requester lost the previous contention.
   assign w_grant_a  = wb_a_valid && (!wb_b_valid || r_last_b);
   assign w_grant_b  = wb_b_valid && !w_grant_a;
   assign wb_a_ready = w_grant_a;
   assign wb_b_ready = w_grant_b;
   assign rf_wr_addr = w_grant_a ? wb_a_addr : wb_b_addr;
   assign rf_wr_data = w_grant_a ? wb_a_data : wb_b_data;
   assign rf_wr_en   = (w_grant_a || w_grant_b) && (rf_wr_addr != '0) && !rst;

   assign rd_req_ready = (r_state == StIdle);
   assign rd_rsp_valid = (r_state == StResp);
   assign rd_rs1_data  = r_rs1_data;
   assign rd_rs2_data  = r_rs2_data;
   assign rf_rs1_addr  = (r_state == StIdle) ? rd_rs1_addr : r_rs1_addr;
   assign rf_rs2_addr  = (r_state == StIdle) ? rd_rs2_addr : r_rs2_addr;

   // rf_wr_en already excludes x0, so an address match implies a nonzero operand.
   function automatic logic [31:0] f_capture(input logic [AddrW-1:0] addr,
                                             input logic              byp_vld,
                                             input logic [31:0]       byp_data,
                                             input logic [31:0]       rf_data);
      if (addr == '0)                              return 32'h0;
      else if (rf_wr_en && (rf_wr_addr == addr))   return rf_wr_data;
      else if (byp_vld)                            return byp_data;
      else                                         return rf_data;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (rd_req_valid) w_state_nxt = StRead;
         StRead:  w_state_nxt = StResp;
         StResp:  if (rd_rsp_ready) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk_core or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_rs1_addr  <= '0;
         r_rs2_addr  <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_byp1_vld  <= 1'b0;
         r_byp2_vld  <= 1'b0;
         r_byp1_data <= '0;
         r_byp2_data <= '0;
         r_last_b    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (wb_a_valid && wb_b_valid) r_last_b <= w_grant_b;
         unique case (r_state)
            StIdle: begin
               if (rd_req_valid) begin
                  r_rs1_addr  <= rd_rs1_addr;
                  r_rs2_addr  <= rd_rs2_addr;
                  // The regfile read launched this cycle returns pre-write data.
                  r_byp1_vld  <= rf_wr_en && (rf_wr_addr == rd_rs1_addr);
                  r_byp2_vld  <= rf_wr_en && (rf_wr_addr == rd_rs2_addr);
                  r_byp1_data <= rf_wr_data;
                  r_byp2_data <= rf_wr_data;
               end
            end
            StRead: begin
               r_rs1_data <= f_capture(r_rs1_addr, r_byp1_vld, r_byp1_data, rf_rs1_data);
               r_rs2_data <= f_capture(r_rs2_addr, r_byp2_vld, r_byp2_data, rf_rs2_data);
               r_byp1_vld <= 1'b0;
               r_byp2_vld <= 1'b0;
            end
            StResp: begin
               if (rf_wr_en && (rf_wr_addr == r_rs1_addr)) r_rs1_data <= rf_wr_data;
               if (rf_wr_en && (rf_wr_addr == r_rs2_addr)) r_rs2_data <= rf_wr_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hsv_core_issue_regfile_ctrl.sv
// Directed bench for hsv_core_issue_regfile_ctrl with a behavioural registered-read regfile.
module tb_hsv_core_issue_regfile_ctrl;

   logic        clk_core = 1'b0;
   logic        rst;
   logic        rd_req_valid, rd_req_ready, rd_rsp_valid, rd_rsp_ready;
   logic [4:0]  rd_rs1_addr, rd_rs2_addr, rf_rs1_addr, rf_rs2_addr, rf_wr_addr;
   logic [31:0] rd_rs1_data, rd_rs2_data, rf_rs1_data, rf_rs2_data, rf_wr_data;
   logic        rf_wr_en;
   logic        wb_a_valid, wb_a_ready, wb_b_valid, wb_b_ready;
   logic [4:0]  wb_a_addr, wb_b_addr;
   logic [31:0] wb_a_data, wb_b_data;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem [32];

   always #5 clk_core = ~clk_core;

   hsv_core_issue_regfile_ctrl #(.NUM_REGS(32)) dut (
      .clk_core     (clk_core),
      .rst          (rst),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_rs1_addr  (rd_rs1_addr),
      .rd_rs2_addr  (rd_rs2_addr),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .rd_rs1_data  (rd_rs1_data),
      .rd_rs2_data  (rd_rs2_data),
      .rf_rs1_addr  (rf_rs1_addr),
      .rf_rs2_addr  (rf_rs2_addr),
      .rf_rs1_data  (rf_rs1_data),
      .rf_rs2_data  (rf_rs2_data),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_data   (rf_wr_data),
      .wb_a_valid   (wb_a_valid),
      .wb_a_ready   (wb_a_ready),
      .wb_a_addr    (wb_a_addr),
      .wb_a_data    (wb_a_data),
      .wb_b_valid   (wb_b_valid),
      .wb_b_ready   (wb_b_ready),
      .wb_b_addr    (wb_b_addr),
      .wb_b_data    (wb_b_data)
   );

   // Regfile: registered read of the old contents, x0 preloaded with junk.
   always @(posedge clk_core) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'hA500_0000 | i;
      end else if (rf_wr_en) begin
         mem[rf_wr_addr] <= rf_wr_data;
      end
      rf_rs1_data <= mem[rf_rs1_addr];
      rf_rs2_data <= mem[rf_rs2_addr];
   end

   task automatic cyc();
      @(posedge clk_core);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      settle();
      n_vec++; if (rd_req_ready !== 1'b1) begin n_err++;
         $display("FAIL reset_req_ready got %0h want 1", rd_req_ready); end
      n_vec++; if (rd_rsp_valid !== 1'b0) begin n_err++;
         $display("FAIL reset_rsp_valid got %0h want 0", rd_rsp_valid); end
      n_vec++; if ({rd_rs1_data, rd_rs2_data} !== 64'h0) begin n_err++;
         $display("FAIL reset_rsp_data got %h %h want 0 0", rd_rs1_data, rd_rs2_data); end
      n_vec++; if (rf_wr_en !== 1'b0) begin n_err++;
         $display("FAIL reset_wr_en got %0h want 0", rf_wr_en); end
      cyc();
   endtask

   task automatic test_read_basic();
      wb_a_valid = 1'b1; wb_a_addr = 5'd5; wb_a_data = 32'hDEAD_BEEF;
      settle();
      n_vec++; if ({wb_a_ready, rf_wr_en, rf_wr_addr} !== {1'b1, 1'b1, 5'd5}) begin n_err++;
         $display("FAIL wr5_ctrl got %b %b %0d want 1 1 5", wb_a_ready, rf_wr_en, rf_wr_addr); end
      n_vec++; if (rf_wr_data !== 32'hDEAD_BEEF) begin n_err++;
         $display("FAIL wr5_data got %h want deadbeef", rf_wr_data); end
      cyc();
      wb_a_valid = 1'b0;
      rd_req_valid = 1'b1; rd_rs1_addr = 5'd5; rd_rs2_addr = 5'd0; rd_rsp_ready = 1'b1;
      settle();
      n_vec++; if ({rd_req_ready, rf_rs1_addr} !== {1'b1, 5'd5}) begin n_err++;
         $display("FAIL rd_T got ready %b addr %0d want 1 5", rd_req_ready, rf_rs1_addr); end
      cyc();
      rd_req_valid = 1'b0; rd_rs1_addr = 5'd9;
      settle();
      n_vec++; if ({rd_req_ready, rd_rsp_valid, rf_rs1_addr} !== {1'b0, 1'b0, 5'd5}) begin n_err++;
         $display("FAIL rd_T1 got %b %b %0d want 0 0 5", rd_req_ready, rd_rsp_valid, rf_rs1_addr);
      end
      cyc();
      settle();
      n_vec++; if ({rd_rsp_valid, rd_req_ready} !== 2'b10) begin n_err++;
         $display("FAIL rd_T2_ctrl got %b %b want 1 0", rd_rsp_valid, rd_req_ready); end
      n_vec++; if ({rd_rs1_data, rd_rs2_data} !== {32'hDEAD_BEEF, 32'h0}) begin n_err++;
         $display("FAIL rd_T2_data got %h %h want deadbeef 0", rd_rs1_data, rd_rs2_data); end
      cyc();
      settle();
      n_vec++; if ({rd_rsp_valid, rd_req_ready} !== 2'b01) begin n_err++;
         $display("FAIL rd_T3 got %b %b want 0 1", rd_rsp_valid, rd_req_ready); end
   endtask

   task automatic test_arbiter();
      logic exp_a;
      wb_a_valid = 1'b1; wb_a_addr = 5'd1; wb_a_data = 32'h11;
      wb_b_valid = 1'b1; wb_b_addr = 5'd2; wb_b_data = 32'h22;
      for (int i = 0; i < 3; i++) begin
         exp_a = (i != 1);
         settle();
         n_vec++; if ({wb_a_ready, wb_b_ready, rf_wr_en} !== {exp_a, !exp_a, 1'b1}) begin n_err++;
            $display("FAIL arb_c%0d got %b %b %b want %b %b 1", i + 1, wb_a_ready, wb_b_ready,
                     rf_wr_en, exp_a, !exp_a); end
         n_vec++; if (rf_wr_addr !== (exp_a ? 5'd1 : 5'd2)) begin n_err++;
            $display("FAIL arb_addr%0d got %0d want %0d", i + 1, rf_wr_addr, exp_a ? 1 : 2); end
         cyc();
      end
      wb_a_valid = 1'b0; wb_b_valid = 1'b0;
   endtask

   task automatic test_bypass();
      rd_req_valid = 1'b1; rd_rs1_addr = 5'd7; rd_rs2_addr = 5'd6; rd_rsp_ready = 1'b1;
      wb_b_valid = 1'b1; wb_b_addr = 5'd7; wb_b_data = 32'h1234;
      settle();
      n_vec++; if ({wb_b_ready, rf_wr_en} !== 2'b11) begin n_err++;
         $display("FAIL byp_T_wr got %b %b want 1 1", wb_b_ready, rf_wr_en); end
      cyc();
      rd_req_valid = 1'b0; wb_b_valid = 1'b0;
      wb_a_valid = 1'b1; wb_a_addr = 5'd7; wb_a_data = 32'h5678;
      cyc();
      wb_a_valid = 1'b0;
      settle();
      n_vec++; if ({rd_rsp_valid, rd_rs1_data} !== {1'b1, 32'h5678}) begin n_err++;
         $display("FAIL byp_read_prec got %b %h want 1 5678", rd_rsp_valid, rd_rs1_data); end
      n_vec++; if (rd_rs2_data !== 32'hA500_0006) begin n_err++;
         $display("FAIL byp_rs2_plain got %h want a5000006", rd_rs2_data); end
      cyc();
      rd_req_valid = 1'b1; rd_rs1_addr = 5'd8; rd_rs2_addr = 5'd8;
      wb_b_valid = 1'b1; wb_b_addr = 5'd8; wb_b_data = 32'h8888;
      cyc();
      rd_req_valid = 1'b0; wb_b_valid = 1'b0;
      cyc();
      settle();
      n_vec++; if ({rd_rs1_data, rd_rs2_data} !== {32'h8888, 32'h8888}) begin n_err++;
         $display("FAIL byp_accept got %h %h want 8888 8888", rd_rs1_data, rd_rs2_data); end
      cyc();
   endtask

   task automatic test_resp_hold();
      rd_req_valid = 1'b1; rd_rs1_addr = 5'd4; rd_rs2_addr = 5'd3; rd_rsp_ready = 1'b0;
      cyc();
      rd_req_valid = 1'b0;
      cyc();
      settle();
      n_vec++; if ({rd_rsp_valid, rd_rs2_data} !== {1'b1, 32'hA500_0003}) begin n_err++;
         $display("FAIL hold_c1 got %b %h want 1 a5000003", rd_rsp_valid, rd_rs2_data); end
      wb_a_valid = 1'b1; wb_a_addr = 5'd3; wb_a_data = 32'hAA;
      cyc();
      wb_a_valid = 1'b0;
      settle();
      n_vec++; if ({rd_rsp_valid, rd_rs2_data} !== {1'b1, 32'hAA}) begin n_err++;
         $display("FAIL hold_c2 got %b %h want 1 aa", rd_rsp_valid, rd_rs2_data); end
      n_vec++; if (rd_rs1_data !== 32'hA500_0004) begin n_err++;
         $display("FAIL hold_rs1 got %h want a5000004", rd_rs1_data); end
      cyc();
      settle();
      n_vec++; if ({rd_rsp_valid, rd_rs2_data} !== {1'b1, 32'hAA}) begin n_err++;
         $display("FAIL hold_c3 got %b %h want 1 aa", rd_rsp_valid, rd_rs2_data); end
      cyc();
      rd_rsp_ready = 1'b1;
      settle();
      n_vec++; if (rd_rsp_valid !== 1'b1) begin n_err++;
         $display("FAIL hold_c4 got %b want 1", rd_rsp_valid); end
      cyc();
      settle();
      n_vec++; if ({rd_rsp_valid, rd_req_ready} !== 2'b01) begin n_err++;
         $display("FAIL hold_release got %b %b want 0 1", rd_rsp_valid, rd_req_ready); end
   endtask

   task automatic test_x0();
      wb_a_valid = 1'b1; wb_a_addr = 5'd0; wb_a_data = 32'hFFFF;
      settle();
      n_vec++; if ({wb_a_ready, rf_wr_en} !== 2'b10) begin n_err++;
         $display("FAIL x0_wr got %b %b want 1 0", wb_a_ready, rf_wr_en); end
      cyc();
      wb_a_valid = 1'b0;
      rd_req_valid = 1'b1; rd_rs1_addr = 5'd0; rd_rs2_addr = 5'd0; rd_rsp_ready = 1'b1;
      cyc();
      rd_req_valid = 1'b0;
      cyc();
      settle();
      n_vec++; if ({rd_rsp_valid, rd_rs1_data, rd_rs2_data} !== {1'b1, 64'h0}) begin n_err++;
         $display("FAIL x0_read got %b %h %h want 1 0 0", rd_rsp_valid, rd_rs1_data, rd_rs2_data);
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      rd_req_valid = 1'b1; rd_rs1_addr = 5'd5; rd_rs2_addr = 5'd5; rd_rsp_ready = 1'b1;
      cyc();
      rd_req_valid = 1'b0;
      wb_a_valid = 1'b1; wb_a_addr = 5'd9; wb_a_data = 32'h99;
      settle();
      n_vec++; if ({rd_req_ready, rf_wr_en} !== 2'b01) begin n_err++;
         $display("FAIL rstmid_pre got %b %b want 0 1", rd_req_ready, rf_wr_en); end
      rst = 1'b1;
      settle();
      n_vec++; if ({rd_req_ready, rd_rsp_valid, rf_wr_en} !== 3'b100) begin n_err++;
         $display("FAIL rstmid_async got %b %b %b want 1 0 0", rd_req_ready, rd_rsp_valid,
                  rf_wr_en); end
      n_vec++; if ({wb_a_ready, rf_wr_addr} !== {1'b1, 5'd9}) begin n_err++;
         $display("FAIL rstmid_wrpath got %b %0d want 1 9", wb_a_ready, rf_wr_addr); end
      cyc();
      rst = 1'b0; wb_a_valid = 1'b0;
      settle();
      n_vec++; if ({rd_req_ready, rd_rsp_valid, rd_rs1_data} !== {2'b10, 32'h0}) begin n_err++;
         $display("FAIL rstmid_after got %b %b %h want 1 0 0", rd_req_ready, rd_rsp_valid,
                  rd_rs1_data); end
      cyc();
      settle();
      n_vec++; if (rd_rsp_valid !== 1'b0) begin n_err++;
         $display("FAIL rstmid_norsp got %b want 0", rd_rsp_valid); end
      wb_a_valid = 1'b1; wb_a_addr = 5'd1; wb_b_valid = 1'b1; wb_b_addr = 5'd2;
      settle();
      n_vec++; if ({wb_a_ready, wb_b_ready} !== 2'b10) begin n_err++;
         $display("FAIL rstmid_arb got %b %b want 1 0", wb_a_ready, wb_b_ready); end
      cyc();
      wb_a_valid = 1'b0; wb_b_valid = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      rd_req_valid = 1'b0; rd_rsp_ready = 1'b0; rd_rs1_addr = '0; rd_rs2_addr = '0;
      wb_a_valid = 1'b0; wb_a_addr = '0; wb_a_data = '0;
      wb_b_valid = 1'b0; wb_b_addr = '0; wb_b_data = '0;
      repeat (3) @(posedge clk_core);
      #1;
      rst = 1'b0;
      test_reset();
      test_read_basic();
      test_arbiter();
      test_bypass();
      test_resp_hold();
      test_x0();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hsv_core_issue_regfile_ctrl.md
HSV_CORE_ISSUE_REGFILE_CTRL -- requirements
Module: hsv_core_issue_regfile_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, meaning number of architectural registers; register addresses are 5 bits wide.
REQ-002 SHALL have port clk_core  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports rd_req_valid in 1, rd_req_ready out 1, rd_rs1_addr in 5, rd_rs2_addr in 5: operand read request from issue.
REQ-005 SHALL have ports rd_rsp_valid out 1, rd_rsp_ready in 1, rd_rs1_data out 32, rd_rs2_data out 32: operand read response.
REQ-006 SHALL have ports rf_rs1_addr out 5, rf_rs2_addr out 5, rf_rs1_data in 32, rf_rs2_data in 32: regfile read side; rf data is the registered read, valid one cycle after the address.
REQ-007 SHALL have ports rf_wr_en out 1, rf_wr_addr out 5, rf_wr_data out 32: regfile write port.
REQ-008 SHALL have ports wb_a_valid in 1, wb_a_ready out 1, wb_a_addr in 5, wb_a_data in 32, and an identical wb_b_* set: two writeback requesters.

Function
REQ-009 Read FSM SHALL have states IDLE, READ, RESP.
REQ-010 rd_req_ready SHALL be 1 only in IDLE; a request is accepted when rd_req_valid && rd_req_ready, moving IDLE->READ.
REQ-011 rf_rs1_addr/rf_rs2_addr SHALL equal rd_rs1_addr/rd_rs2_addr combinationally in IDLE, and the latched request addresses in READ and RESP.
REQ-012 READ SHALL last exactly one cycle, then go to RESP; at the end of READ the rf data SHALL be captured into the response registers.
REQ-013 rd_rsp_valid SHALL be 1 only in RESP; RESP->IDLE when rd_rsp_ready=1; otherwise hold, with data stable except per REQ-016.
REQ-014 Latency: request accepted in cycle T -> rd_rsp_valid=1 in cycle T+2; maximum throughput 1 request per 3 cycles.
REQ-015 Bypass: a rf write in the accept cycle T or the READ cycle to a latched nonzero address SHALL override the captured value with rf_wr_data; a write in READ takes precedence over one in T.
REQ-016 In RESP, a rf write to a matching nonzero address SHALL update the held response data at that edge.
REQ-017 Address 0 operands SHALL always return 32'h0, regardless of rf data or bypass.
REQ-018 Write arbiter: exactly one of wb_a/wb_b granted per cycle; wb_x_ready = grant_x, combinational, not dependent on read FSM.
REQ-019 Only one requester valid -> that requester is granted; both valid -> grant the one not granted last; the last_grant register updates only on a two-way contention grant.
REQ-020 Granted write with addr!=0 -> rf_wr_en=1 and rf_wr_addr/rf_wr_data equal the granted requester's, same cycle; addr==0 -> accepted (ready=1) but rf_wr_en=0.
REQ-021 No valid requester -> rf_wr_en=0; rf_wr_addr/rf_wr_data are don't-care.

Reset
REQ-022 On rst assertion: FSM->IDLE immediately, rd_rsp_valid=0, response data=0, latched addresses=0, bypass flags cleared, last_grant=B (so A wins first contention).
REQ-023 Reset mid-READ or mid-RESP SHALL abandon the request with no response emitted; write outputs are combinational and follow inputs during reset except rf_wr_en, which SHALL be 0 while rst=1.

Verification
REQ-024 Write x5=0xDEADBEEF via wb_a, then read rs1=5, rs2=0 with rsp_ready=1 -> rd_rsp_valid at T+2, rs1=0xDEADBEEF, rs2=0, rd_req_ready low at T+1 and T+2.
REQ-025 wb_a and wb_b both valid for 3 cycles (x1, x2) -> grants A,B,A; rf_wr_en high each cycle; wb_b_ready=0 in cycles 1 and 3.
REQ-026 Read rs1=7 accepted in T while wb_b writes x7=0x1234 in T, then wb_a writes x7=0x5678 in READ -> response rs1=0x5678.
REQ-027 Hold rsp_ready=0 in RESP for 4 cycles while writing x3=0xAA to matching rs2=3 -> rd_rs2_data becomes 0xAA the cycle after the write, valid stays high, IDLE after rsp_ready=1.
REQ-028 wb_a writes x0=0xFFFF -> wb_a_ready=1, rf_wr_en=0; a subsequent read of x0 returns 0.
REQ-029 Assert rst during READ -> next cycle rd_req_ready=1, rd_rsp_valid=0; first contention after reset grants A.
